// File: rtl/generate_sequence_using_fsm_if.sv
// Request/serial-output bundle for the serial pattern transmitter.
// The master modport drives requests, and the slave modport produces the serial stream.
interface generate_sequence_using_fsm_if #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap;
  logic             ready;
  logic             busy;
  logic             out_bit;
  logic             out_valid;
  logic             done;

  modport master (
    output start, pattern, repeat_cnt, gap,
    input  ready, busy, out_bit, out_valid, done
  );

  modport slave (
    input  start, pattern, repeat_cnt, gap,
    output ready, busy, out_bit, out_valid, done
  );
endinterface

// File: rtl/generate_sequence_using_fsm.sv
// Serial pattern transmitter: sends a latched WIDTH-bit pattern MSB-first,
// repeated repeat_cnt times with gap idle cycles between repetitions.
module generate_sequence_using_fsm #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  generate_sequence_using_fsm_if.slave  bus
);

  localparam int               IDX_W   = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [CNT_W-1:0] REP_ONE = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state,   w_state_nxt;
  logic [WIDTH-1:0] r_pat,     w_pat_nxt;
  logic [CNT_W-1:0] r_reps,    w_reps_nxt;
  logic [GAP_W-1:0] r_gap,     w_gap_nxt;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
  logic [IDX_W-1:0] r_idx,     w_idx_nxt;
  logic             r_out_bit, w_out_bit_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_done,    w_done_nxt;
  logic             w_ready;

  function automatic logic pick_bit(input logic [WIDTH-1:0] p,
                                    input logic [IDX_W-1:0] i);
    return p[i];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pat       <= '0;
      r_reps      <= '0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      r_idx       <= '0;
      r_out_bit   <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pat       <= w_pat_nxt;
      r_reps      <= w_reps_nxt;
      r_gap       <= w_gap_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_out_bit   <= w_out_bit_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Registered outputs are derived from the next state, so they line up with
  // the state being entered rather than lagging it by a cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_pat_nxt     = r_pat;
    w_reps_nxt    = r_reps;
    w_gap_nxt     = r_gap;
    w_gap_cnt_nxt = r_gap_cnt;
    w_idx_nxt     = r_idx;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_pat_nxt   = bus.pattern;
          w_reps_nxt  = bus.repeat_cnt;
          w_gap_nxt   = bus.gap;
          w_idx_nxt   = IDX_MSB;
          w_state_nxt = (bus.repeat_cnt != '0) ? S_SEND : S_DONE;
        end
      end
      S_SEND: begin
        if (r_idx == '0) begin
          w_reps_nxt = r_reps - REP_ONE;
          w_idx_nxt  = IDX_MSB;
          if (w_reps_nxt == '0) begin
            w_state_nxt = S_DONE;
          end else if (r_gap == '0) begin
            w_state_nxt = S_SEND;
          end else begin
            // Loaded with gap-1 so the GAP state lasts exactly gap cycles.
            w_state_nxt   = S_GAP;
            w_gap_cnt_nxt = r_gap - GAP_ONE;
          end
        end else begin
          w_idx_nxt = r_idx - IDX_ONE;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = S_SEND;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_ONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_out_valid_nxt = (w_state_nxt == S_SEND);
    w_out_bit_nxt   = w_out_valid_nxt & pick_bit(w_pat_nxt, w_idx_nxt);
    w_done_nxt      = (w_state_nxt == S_DONE);
  end

  assign w_ready       = (r_state == S_IDLE);
  assign bus.ready     = w_ready;
  assign bus.busy      = ~w_ready;
  assign bus.out_bit   = r_out_bit;
  assign bus.out_valid = r_out_valid;
  assign bus.done      = r_done;

endmodule
